// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the multi-cycle MIPS controller:
//   - FSM state encoding
//   - opcode / funct constants for the supported subset
//   - instruction class latched between DECODE and the later states
//   - datapath control encodings (alu_ctl, alu_src_b, pc_src)
//   - ctl_t: one bundle holding every control output
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  // alu_ctl encodings
  localparam logic [1:0] ALU_ADDU = 2'b00;
  localparam logic [1:0] ALU_SUBU = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pc_src encodings
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Instruction class. Legality is carried separately, so the reset
  // value CLS_J carries no meaning until the first DECODE.
  typedef enum logic [2:0] {
    CLS_J    = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_ADDU = 3'd3,
    CLS_SUBU = 3'd4,
    CLS_ORI  = 3'd5,
    CLS_LUI  = 3'd6,
    CLS_BEQ  = 3'd7
  } iclass_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctl;
    logic       ext_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  function automatic logic is_rtype(input iclass_t cls);
    return (cls == CLS_ADDU) || (cls == CLS_SUBU);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode
// Combinational opcode/funct decode into an instruction class plus a
// legal flag. Used by the controller while in DECODE.
// Ports:
//   i_opcode  in   6  IR[31:26]
//   i_funct   in   6  IR[5:0]
//   o_cls     out  3  instruction class (meaningful only when o_legal=1)
//   o_legal   out  1  opcode/funct belongs to the supported subset
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output iclass_t    o_cls,
  output logic       o_legal
);

  always_comb begin
    o_cls   = CLS_J;
    o_legal = 1'b0;
    unique case (i_opcode)
      OP_RTYPE: begin
        if (i_funct == FN_ADDU) begin
          o_cls   = CLS_ADDU;
          o_legal = 1'b1;
        end else if (i_funct == FN_SUBU) begin
          o_cls   = CLS_SUBU;
          o_legal = 1'b1;
        end
      end
      OP_ORI: begin o_cls = CLS_ORI; o_legal = 1'b1; end
      OP_LUI: begin o_cls = CLS_LUI; o_legal = 1'b1; end
      OP_LW:  begin o_cls = CLS_LW;  o_legal = 1'b1; end
      OP_SW:  begin o_cls = CLS_SW;  o_legal = 1'b1; end
      OP_BEQ: begin o_cls = CLS_BEQ; o_legal = 1'b1; end
      OP_J:   begin o_cls = CLS_J;   o_legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Multi-cycle MIPS control FSM for addu, subu, ori, lw, sw, beq, lui, j.
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   opcode, funct       IR fields
//   zero                ALU zero flag (current cycle)
//   mem_ready           memory finishes the current access this cycle
//   mem_req, mem_write  memory request / write qualifier
//   i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctl,
//   ext_op, reg_write, reg_dst, mem_to_reg   datapath controls
//   instr_done          one-cycle pulse in the last state of an instruction
//   illegal             one-cycle pulse in DECODE for an unsupported op
//   dbg_state           current FSM state
//
// Memory handshake: mem_req is a level. Once raised it stays high with
// i_or_d and mem_write unchanged until the cycle in which mem_ready=1;
// that cycle completes the access and the FSM leaves the state on the
// following edge. mem_ready is ignored whenever mem_req is low.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctl,
  output logic       ext_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] dbg_state
);

  state_t  r_state;
  state_t  w_next;
  iclass_t r_cls;
  iclass_t w_cls;
  logic    w_legal;
  logic    r_run;
  ctl_t    w_ctl;
  ctl_t    w_out;

  mc_decode u_decode (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_cls    (w_cls),
    .o_legal  (w_legal)
  );

  // Reset release is synchronised by one flop; until it sets, every
  // output is held at 0 and FETCH cannot advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Class is captured as DECODE exits so later states never look at IR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cls <= CLS_J;
    else if (r_state == S_DECODE)  r_cls <= w_cls;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:   if (r_run && mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal) begin
          w_next = S_FETCH;
        end else begin
          unique case (w_cls)
            CLS_LW, CLS_SW:     w_next = S_MEM_ADR;
            CLS_ADDU, CLS_SUBU: w_next = S_EXEC_R;
            CLS_ORI, CLS_LUI:   w_next = S_EXEC_I;
            CLS_BEQ:            w_next = S_BRANCH;
            CLS_J:              w_next = S_JUMP;
            default:            w_next = S_FETCH;
          endcase
        end
      end
      S_MEM_ADR: w_next = (r_cls == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:  w_next = S_FETCH;
      S_MEM_WR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC_R:  w_next = S_ALU_WB;
      S_EXEC_I:  w_next = S_ALU_WB;
      S_ALU_WB:  w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctl = '0;
    unique case (r_state)
      S_FETCH: begin
        w_ctl.mem_req   = 1'b1;
        w_ctl.alu_src_b = SRCB_FOUR;
        w_ctl.alu_ctl   = ALU_ADDU;
        w_ctl.pc_src    = PC_ALU;
        w_ctl.ir_write  = mem_ready;
        w_ctl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target PC+4+(imm<<2) is computed here into ALUOut.
        w_ctl.alu_src_b = SRCB_IMM_SH;
        w_ctl.ext_op    = 1'b1;
        w_ctl.alu_ctl   = ALU_ADDU;
        w_ctl.illegal   = !w_legal;
      end
      S_MEM_ADR: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.ext_op    = 1'b1;
        w_ctl.alu_ctl   = ALU_ADDU;
      end
      S_MEM_RD: begin
        w_ctl.mem_req = 1'b1;
        w_ctl.i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        w_ctl.mem_req    = 1'b1;
        w_ctl.mem_write  = 1'b1;
        w_ctl.i_or_d     = 1'b1;
        w_ctl.instr_done = mem_ready;
      end
      S_EXEC_R: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_B;
        w_ctl.alu_ctl   = (r_cls == CLS_SUBU) ? ALU_SUBU : ALU_ADDU;
      end
      S_EXEC_I: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_ctl   = (r_cls == CLS_LUI) ? ALU_LUI : ALU_OR;
      end
      S_ALU_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = is_rtype(r_cls);
        w_ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a  = 1'b1;
        w_ctl.alu_src_b  = SRCB_B;
        w_ctl.alu_ctl    = ALU_SUBU;
        w_ctl.pc_src     = PC_ALUOUT;
        w_ctl.pc_write   = zero;
        w_ctl.instr_done = 1'b1;
      end
      S_JUMP: begin
        w_ctl.pc_src     = PC_JUMP;
        w_ctl.pc_write   = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // r_run clears asynchronously with rst_n, so this gate also gives
  // all-zero outputs the instant reset asserts.
  assign w_out = r_run ? w_ctl : '0;

  assign mem_req    = w_out.mem_req;
  assign mem_write  = w_out.mem_write;
  assign i_or_d     = w_out.i_or_d;
  assign ir_write   = w_out.ir_write;
  assign pc_write   = w_out.pc_write;
  assign pc_src     = w_out.pc_src;
  assign alu_src_a  = w_out.alu_src_a;
  assign alu_src_b  = w_out.alu_src_b;
  assign alu_ctl    = w_out.alu_ctl;
  assign ext_op     = w_out.ext_op;
  assign reg_write  = w_out.reg_write;
  assign reg_dst    = w_out.reg_dst;
  assign mem_to_reg = w_out.mem_to_reg;
  assign instr_done = w_out.instr_done;
  assign illegal    = w_out.illegal;
  assign dbg_state  = r_state;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences the multi-cycle MIPS datapath for the supported subset: addu, subu, ori, lw, sw, beq, lui, j. Each instruction is broken into fetch, decode, execute, memory and write-back steps. A single shared instruction/data memory is accessed through a req/ready handshake. The block sits between the instruction register (opcode/funct) and the datapath mux/enable controls, replacing per-instruction combinational control.

## Interface
- No parameters.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag, current cycle.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  access is a write (valid with mem_req).
- i_or_d  output  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load IR from memory read data.
- pc_write  output  1  load PC this cycle.
- pc_src  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target {PC[31:28], IR[25:0], 2'b00}.
- alu_src_a  output  1  0 = PC, 1 = A register.
- alu_src_b  output  2  00 B register, 01 constant 4, 10 extended imm, 11 extended imm << 2.
- alu_ctl  output  2  00 addu, 01 subu, 10 or, 11 lui.
- ext_op  output  1  1 = sign-extend imm16, 0 = zero-extend.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  0 = rt, 1 = rd.
- mem_to_reg  output  1  write-back source: 0 = ALUOut, 1 = MDR.
- instr_done  output  1  one-cycle pulse in the final state of each retired instruction.
- illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode/funct.

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP.
- FETCH:
  - mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctl=00, pc_src=00.
  - ir_write and pc_write are asserted only when mem_ready=1, which is also the advance to DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ext_op=1, alu_ctl=00 (branch target into ALUOut). Next state:
  - lw/sw → MEM_ADR
  - addu/subu → EXEC_R
  - ori/lui → EXEC_I
  - beq → BRANCH
  - j → JUMP
  - anything else → FETCH with illegal=1
- MEM_ADR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_ctl=00. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, i_or_d=1. Holds until mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 → FETCH.
- MEM_WR: mem_req=1, mem_write=1, i_or_d=1. Holds until mem_ready; on mem_ready, instr_done=1 → FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctl = 00 (addu) / 01 (subu) → ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, ext_op=0, alu_ctl = 10 (ori) / 11 (lui) → ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst = 1 for R-type, 0 for I-type; instr_done=1 → FETCH.
  - R-type vs I-type selection uses the latched opcode class, not a re-decode.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctl=01, pc_src=01, pc_write=zero, instr_done=1 → FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 → FETCH.
- Every output not listed for a state is 0.
- All outputs are combinational from state plus mem_ready/zero.
- The opcode class is latched into a 3-bit register on the DECODE exit edge. IR is stable after FETCH, but the latch keeps later states independent of opcode glitches.

## Timing
- Reset:
  - rst_n low forces state=FETCH and the class register to 0 immediately (asynchronous).
  - Every output is 0 while rst_n=0; mem_req is gated by synchronised reset release.
  - The first mem_req appears in the first cycle after rst_n rises.
- Latency with mem_ready tied high:
  - R-type and ori/lui: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq and j: 3 cycles
  - illegal: 2 cycles
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Request/write level rules:
  - mem_req stays high and stable until the ready cycle.
  - mem_write is held constant across the whole wait.
- Reset asserted mid-instruction (including during a memory wait) abandons it: no reg_write, pc_write or mem_write after the reset edge.
- Pulse rules:
  - instr_done and illegal never assert in the same cycle.
  - instr_done asserts exactly once per retired instruction.

## Structure
- Shared package mips_pkg holds:
  - the state enum
  - opcode and funct constants (addu 100001, subu 100011, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010)
  - alu_ctl, alu_src_b and pc_src encodings
- One sub-module, mc_decode: combinational opcode/funct → instruction-class and legal-flag decode, used by DECODE.
- The FSM (state register, next-state logic, output decode) lives in multicycle_controller.

## Test plan
- Reset: rst_n=0 during a MEM_RD wait → all outputs 0 immediately. Release → FETCH with mem_req=1 on the next cycle.
- addu (000000/100001), mem_ready=1: states FETCH, DECODE, EXEC_R, ALU_WB. ALU_WB shows reg_write=1, reg_dst=1, alu_ctl 00 in EXEC_R, instr_done in cycle 4.
- lw (100011), mem_ready low for 2 cycles in MEM_RD → 7 cycles total. mem_req held high for 3 cycles with i_or_d=1, then MEM_WB with mem_to_reg=1, reg_dst=0.
- beq with zero=1 → pc_write=1, pc_src=01 in cycle 3. beq with zero=0 → pc_write=0, instr_done=1.
- j (000010) → cycle 3 shows pc_write=1, pc_src=10. The following ori (001101) shows ext_op=0, alu_src_b=10, alu_ctl=10.
- opcode 111111, and opcode 000000 with funct 100000 → illegal pulse in DECODE, return to FETCH, no reg_write, mem_write or pc_write beyond the fetch increment.
